// File: rtl/neuron_mac_unit.sv
// -----------------------------------------------------------------------------
// neuron_mac_unit
//
// One neuron of a layer. It sits directly downstream of RAMMux, with one
// instance for each weightN/writeN pair.
//
// Operation:
//   - Loads N_INPUTS signed weights from the weight RAM path while idle.
//   - On a rising edge of sum_trigger, runs a sequential multiply-accumulate
//     of those weights against the unsigned layer input vector.
//   - Scales the sum by an arithmetic right shift and applies the activation.
//   - Presents the output on result, together with a one-cycle done pulse.
//
// Configuration macro: NEURON_RELU_EN
//   defined   : ReLU with unsigned saturation to [0, 2^W_WIDTH-1]
//   undefined : two's-complement truncation of the scaled sum to W_WIDTH bits
//
// Ports:
//   clk           in   1                  rising-edge clock
//   reset         in   1                  synchronous, active-high
//   weight        in   W_WIDTH            signed weight byte from RAMMux
//   write         in   1                  weight write strobe (honoured in IDLE only)
//   unit_address  in   clog2(N_INPUTS)    weight slot index
//   sum_trigger   in   1                  start request (rising-edge detected)
//   x_in          in   N_INPUTS*W_WIDTH   unsigned inputs, slot i at [i*W_WIDTH +: W_WIDTH]
//   result        out  W_WIDTH            neuron output, held until the next done
//   done          out  1                  one-cycle pulse when result updates
//   busy          out  1                  high in every state except IDLE
//
// States:
//   IDLE | accept weight writes, wait for a sum_trigger rising edge
//   LOAD | capture x_in, clear accumulator and slot index
//   MAC  | one weight*input product per cycle into the accumulator
//   ACT  | scale, activate, update result and pulse done
// -----------------------------------------------------------------------------
module neuron_mac_unit #(
  parameter int N_INPUTS  = 4,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 20,
  parameter int FRAC_BITS = 7,
  localparam int IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [W_WIDTH-1:0]           weight,
  input  logic                         write,
  input  logic [IDX_W-1:0]             unit_address,
  input  logic                         sum_trigger,
  input  logic [N_INPUTS*W_WIDTH-1:0]  x_in,
  output logic [W_WIDTH-1:0]           result,
  output logic                         done,
  output logic                         busy
);

  localparam int PROD_W = 2*W_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    ACT  = 2'd3
  } state_t;

  state_t                     state;
  logic                       trig_prev;
  logic                       trig_edge;
  logic signed [W_WIDTH-1:0]  wreg [N_INPUTS];
  logic        [W_WIDTH-1:0]  xreg [N_INPUTS];
  logic signed [ACC_WIDTH-1:0] acc;
  logic        [IDX_W-1:0]    idx;

  logic signed [PROD_W-1:0]    w_ext;
  logic signed [PROD_W-1:0]    x_ext;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic        [W_WIDTH-1:0]   act_val;

  assign trig_edge = sum_trigger & ~trig_prev;

  // Weight is sign-extended and input zero-extended to the full product width.
  // This makes the low PROD_W bits of the product the exact signed result.
  always_comb begin
    w_ext    = {{(W_WIDTH+1){wreg[idx][W_WIDTH-1]}}, wreg[idx]};
    x_ext    = {{(W_WIDTH+1){1'b0}}, xreg[idx]};
    prod     = w_ext * x_ext;
    prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
  end

`ifdef NEURON_RELU_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**W_WIDTH) - 1);
  logic signed [ACC_WIDTH-1:0] scaled;

  always_comb begin
    scaled  = acc >>> FRAC_BITS;
    act_val = '0;
    if (scaled < 0)
      act_val = '0;
    else if (scaled > SAT_MAX)
      act_val = '1;
    else
      act_val = scaled[W_WIDTH-1:0];
  end
`else
  always_comb begin
    act_val = W_WIDTH'(acc >>> FRAC_BITS);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      trig_prev <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
        wreg[i] <= '0;
        xreg[i] <= '0;
      end
    end else begin
      trig_prev <= sum_trigger;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          // A write and a trigger in the same cycle both take effect.
          // The new weight is in place before the first MAC cycle reads it.
          if (write && (int'(unit_address) < N_INPUTS))
            wreg[unit_address] <= weight;
          if (trig_edge) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          for (int i = 0; i < N_INPUTS; i++)
            xreg[i] <= x_in[i*W_WIDTH +: W_WIDTH];
          acc   <= '0;
          idx   <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (idx == LAST_IDX)
            state <= ACT;
          else
            idx <= idx + 1'b1;
        end
        ACT: begin
          result <= act_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
module tb_neuron_mac_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  weight;
  logic        write;
  logic [1:0]  unit_address;
  logic        sum_trigger;
  logic [31:0] x_in;
  logic [7:0]  result;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef NEURON_RELU_EN
  localparam logic [7:0] EXP_NEG = 8'h00;
  localparam logic [7:0] EXP_SAT = 8'hFF;
`else
  localparam logic [7:0] EXP_NEG = 8'hFC;
  localparam logic [7:0] EXP_SAT = 8'hF4;
`endif

  neuron_mac_unit dut (
    .clk          (clk),
    .reset        (reset),
    .weight       (weight),
    .write        (write),
    .unit_address (unit_address),
    .sum_trigger  (sum_trigger),
    .x_in         (x_in),
    .result       (result),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic load_w(input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] wv [4];
    wv = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      write = 1'b1;
      unit_address = 2'(i);
      weight = wv[i];
    end
    @(negedge clk);
    write = 1'b0;
  endtask

  // Trigger edge sampled at edge e; lat counts edges after e until done is seen.
  task automatic run_mac(input logic [31:0] xv, output int lat, output logic [7:0] res,
                         output logic busy_at_done, output logic done_after);
    @(negedge clk);
    x_in = xv;
    sum_trigger = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sum_trigger = 1'b0;
    lat = -1;
    res = 8'h00;
    busy_at_done = 1'b1;
    done_after = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) x_in = ~xv;
      if (done) begin
        lat = k;
        res = result;
        busy_at_done = busy;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      done_after = done;
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [7:0] res;
    logic b, d;
    reset = 1'b1; write = 1'b0; sum_trigger = 1'b0;
    weight = 8'h00; unit_address = 2'd0; x_in = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %0h exp 0", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    run_mac(32'hDEADBEEF, lat, res, b, d);
    checks++; if (lat !== 6) begin errors++; $display("FAIL zero_w_latency got %0d exp 6", lat); end
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL zero_w_result got %0h exp 0", res); end
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] res;
    logic b, d;
    load_w(8'd64, 8'd64, 8'd64, 8'd64);
    run_mac({8'd40, 8'd30, 8'd20, 8'd10}, lat, res, b, d);
    checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency got %0d exp 6", lat); end
    checks++; if (res !== 8'd50) begin errors++; $display("FAIL basic_result got %0d exp 50", res); end
    checks++; if (b !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", b); end
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", d); end
  endtask

  task automatic test_negative();
    int lat;
    logic [7:0] res;
    logic b, d;
    load_w(8'h80, 8'h80, 8'h80, 8'h80);
    run_mac({8'd1, 8'd1, 8'd1, 8'd1}, lat, res, b, d);
    checks++; if (lat !== 6) begin errors++; $display("FAIL neg_latency got %0d exp 6", lat); end
    checks++; if (res !== EXP_NEG) begin errors++; $display("FAIL neg_result got %0h exp %0h", res, EXP_NEG); end
  endtask

  task automatic test_saturate();
    int lat;
    logic [7:0] res;
    logic b, d;
    load_w(8'd127, 8'd127, 8'd127, 8'd127);
    run_mac({8'd255, 8'd255, 8'd255, 8'd255}, lat, res, b, d);
    checks++; if (lat !== 6) begin errors++; $display("FAIL sat_latency got %0d exp 6", lat); end
    checks++; if (res !== EXP_SAT) begin errors++; $display("FAIL sat_result got %0h exp %0h", res, EXP_SAT); end
  endtask

  task automatic test_mixed();
    int lat;
    logic [7:0] res;
    logic b, d;
    // 127*200 - 255 + 2*100 + 0 = 25345; >>>7 = 198
    load_w(8'h7F, 8'hFF, 8'h02, 8'h00);
    run_mac({8'd9, 8'd100, 8'd255, 8'd200}, lat, res, b, d);
    checks++; if (res !== 8'd198) begin errors++; $display("FAIL mixed_result got %0d exp 198", res); end
  endtask

  task automatic test_level_hold();
    int ndone;
    load_w(8'd64, 8'd64, 8'd64, 8'd64);
    @(negedge clk);
    x_in = {8'd40, 8'd30, 8'd20, 8'd10};
    sum_trigger = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    @(negedge clk);
    sum_trigger = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL level_hold_dones got %0d exp 1", ndone); end
  endtask

  task automatic test_ignore_during_mac();
    int ndone, first;
    int lat;
    logic [7:0] res, res_first;
    logic b, d;
    load_w(8'd64, 8'd64, 8'd64, 8'd64);
    @(negedge clk);
    x_in = {8'd40, 8'd30, 8'd20, 8'd10};
    sum_trigger = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sum_trigger = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sum_trigger = 1'b1;
    write = 1'b1;
    weight = 8'd99;
    unit_address = 2'd0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_mac got %b exp 1", busy); end
    @(posedge clk);
    #1;
    ndone = 0; first = -1; res_first = 8'h00;
    if (done) begin ndone++; first = 3; res_first = result; end
    @(negedge clk);
    sum_trigger = 1'b0;
    write = 1'b0;
    for (int k = 4; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) begin first = k; res_first = result; end
      end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
    checks++; if (first !== 6) begin errors++; $display("FAIL ignore_latency got %0d exp 6", first); end
    checks++; if (res_first !== 8'd50) begin errors++; $display("FAIL ignore_result got %0d exp 50", res_first); end
    run_mac({8'd40, 8'd30, 8'd20, 8'd10}, lat, res, b, d);
    checks++; if (res !== 8'd50) begin errors++; $display("FAIL ignore_weight_kept got %0d exp 50", res); end
  endtask

  task automatic test_write_with_trigger();
    int lat;
    logic [7:0] res;
    load_w(8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    write = 1'b1;
    unit_address = 2'd0;
    weight = 8'd64;
    x_in = {8'd0, 8'd0, 8'd0, 8'd128};
    sum_trigger = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write = 1'b0;
    sum_trigger = 1'b0;
    lat = -1; res = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = k; res = result; break; end
    end
    checks++; if (lat !== 6) begin errors++; $display("FAIL wr_trig_latency got %0d exp 6", lat); end
    checks++; if (res !== 8'h40) begin errors++; $display("FAIL wr_trig_result got %0h exp 40", res); end
  endtask

  task automatic test_reset_abort();
    int ndone;
    int lat;
    logic [7:0] res;
    logic b, d;
    load_w(8'd64, 8'd64, 8'd64, 8'd64);
    @(negedge clk);
    x_in = {8'd40, 8'd30, 8'd20, 8'd10};
    sum_trigger = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sum_trigger = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL abort_result got %0h exp 0", result); end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_stray_done got %0d exp 0", ndone); end
    run_mac({8'd40, 8'd30, 8'd20, 8'd10}, lat, res, b, d);
    checks++; if (lat !== 6) begin errors++; $display("FAIL post_abort_latency got %0d exp 6", lat); end
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL post_abort_result got %0h exp 0", res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturate();
    test_mixed();
    test_level_hold();
    test_ignore_during_mac();
    test_write_with_trigger();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
